// File: rtl/sprite_motion_if.sv
// sprite_motion_if: inputs (frame strobe, pixel, keys, tile probes) and outputs (pose, hit test, scroll) of the sprite controller
interface sprite_motion_if #(
  parameter int COORD_W = 10,
  parameter int AF_W    = 2
);
  logic               frame_clk;
  logic [COORD_W-1:0] DrawX, DrawY;
  logic               key_left, key_right, key_jump;
  logic [2:0]         blk_up, blk_down, blk_left, blk_right;
  logic [COORD_W-1:0] Pos_X, Pos_Y;
  logic               is_sprite, Shift;
  logic [1:0]         state;
  logic               direction;
  logic [AF_W-1:0]    anim_frame;
  modport master (
    output frame_clk, DrawX, DrawY, key_left, key_right, key_jump,
           blk_up, blk_down, blk_left, blk_right,
    input  Pos_X, Pos_Y, is_sprite, Shift, state, direction, anim_frame
  );
  modport slave (
    input  frame_clk, DrawX, DrawY, key_left, key_right, key_jump,
           blk_up, blk_down, blk_left, blk_right,
    output Pos_X, Pos_Y, is_sprite, Shift, state, direction, anim_frame
  );
endinterface

// File: rtl/sprite_motion.sv
// sprite_motion: per-frame GROUND/RISE/FALL player controller with variable jumps, gravity, scroll requests and walk animation
module sprite_motion #(
  parameter int COORD_W     = 10,
  parameter int X_MIN       = 120,
  parameter int X_MAX       = 519,
  parameter int Y_MIN       = 40,
  parameter int Y_MAX       = 439,
  parameter int SIZE_X      = 20,
  parameter int SIZE_Y      = 20,
  parameter int RESET_X     = 140,
  parameter int WALK_STEP   = 2,
  parameter int AIR_STEP    = 1,
  parameter int RISE_STEP   = 2,
  parameter int JUMP_MIN    = 8,
  parameter int JUMP_MAX    = 127,
  parameter int FALL_MAX    = 4,
  parameter int GRAV_DIV    = 6,
  parameter int ANIM_DIV    = 10,
  parameter int ANIM_FRAMES = 3,
  parameter int SCROLL_X    = 299,
  parameter int SCROLL_AMT  = 40
) (
  input logic          Clk,
  input logic          Reset_n,
  sprite_motion_if.slave bus
);
  localparam int W1   = COORD_W + 1;
  localparam int AF_W = $clog2(ANIM_FRAMES + 1);
  localparam int RC_W = $clog2(JUMP_MAX + 1);
  localparam int FV_W = $clog2(FALL_MAX + 1);
  localparam int GC_W = $clog2(GRAV_DIV + 1);
  localparam int AC_W = $clog2(ANIM_DIV + 1);
  localparam logic [W1-1:0] Y_FLOOR = W1'(Y_MAX - SIZE_Y + 1);
  typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} state_e;
  state_e             st_q, st_d;
  logic [2:0]         sync_q;
  logic               tick_q;
  logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic               dir_q, dir_d, shift_q, shift_d, jump_prev_q, jump_prev_d;
  logic [AF_W-1:0]    anim_frame_q, anim_frame_d;
  logic [AC_W-1:0]    anim_cnt_q, anim_cnt_d;
  logic [RC_W-1:0]    rise_cnt_q, rise_cnt_d;
  logic [FV_W-1:0]    fall_vel_q, fall_vel_d;
  logic [GC_W-1:0]    grav_cnt_q, grav_cnt_d;
  logic [W1-1:0]      x_w, y_w, step, x_mv, y_sum, y_fall;
  logic               left_only, right_only, jump_edge, rise_stop, grav_wrap;
  // frame_clk is asynchronous: two sync flops, then a third flop for the edge reference
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], bus.frame_clk};
      tick_q <= sync_q[1] & ~sync_q[2];
    end
  end
  assign x_w        = {1'b0, pos_x_q};
  assign y_w        = {1'b0, pos_y_q};
  assign left_only  = bus.key_left & ~bus.key_right;
  assign right_only = bus.key_right & ~bus.key_left;
  assign jump_edge  = bus.key_jump & ~jump_prev_q;
  assign step       = st_q == GROUND ? W1'(WALK_STEP) : W1'(AIR_STEP);
  assign x_mv       = (left_only && ~|bus.blk_left && x_w >= W1'(X_MIN) + step) ? x_w - step :
                      (right_only && ~|bus.blk_right && x_w + W1'(SIZE_X - 1) + step <= W1'(X_MAX)) ? x_w + step :
                      x_w;
  assign y_sum      = y_w + W1'(fall_vel_q);
  assign y_fall     = y_sum > Y_FLOOR ? Y_FLOOR : y_sum;
  assign rise_stop  = |bus.blk_up || y_w < W1'(Y_MIN + RISE_STEP) || rise_cnt_q == RC_W'(JUMP_MAX) ||
                      (!bus.key_jump && rise_cnt_q >= RC_W'(JUMP_MIN));
  assign grav_wrap  = grav_cnt_q == GC_W'(GRAV_DIV - 1);
  always_comb begin
    st_d         = st_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    dir_d        = dir_q;
    shift_d      = 1'b0;
    jump_prev_d  = jump_prev_q;
    anim_frame_d = anim_frame_q;
    anim_cnt_d   = anim_cnt_q;
    rise_cnt_d   = rise_cnt_q;
    fall_vel_d   = fall_vel_q;
    grav_cnt_d   = grav_cnt_q;
    if (tick_q) begin
      jump_prev_d = bus.key_jump;
      dir_d       = left_only ? 1'b1 : right_only ? 1'b0 : dir_q;
      shift_d     = x_mv > W1'(SCROLL_X);
      pos_x_d     = shift_d ? COORD_W'(x_mv - W1'(SCROLL_AMT)) : COORD_W'(x_mv);
      if (!(left_only || right_only)) begin
        anim_frame_d = '0;
        anim_cnt_d   = '0;
      end else if (st_q == GROUND) begin
        anim_cnt_d   = anim_cnt_q == AC_W'(ANIM_DIV - 1) ? '0 : anim_cnt_q + AC_W'(1);
        anim_frame_d = anim_cnt_q != AC_W'(ANIM_DIV - 1) ? anim_frame_q :
                       anim_frame_q == AF_W'(ANIM_FRAMES) ? AF_W'(1) : anim_frame_q + AF_W'(1);
      end
      if (st_q == GROUND) begin
        if (jump_edge && ~|bus.blk_up) begin
          st_d       = RISE;
          rise_cnt_d = RC_W'(1);
          pos_y_d    = pos_y_q - COORD_W'(RISE_STEP);
        end else if (~|bus.blk_down && y_w < Y_FLOOR) begin
          st_d       = FALL;
          fall_vel_d = FV_W'(1);
          grav_cnt_d = '0;
        end
      end else if (st_q == RISE) begin
        if (rise_stop) begin
          st_d       = FALL;
          fall_vel_d = FV_W'(1);
          grav_cnt_d = '0;
        end else begin
          pos_y_d    = pos_y_q - COORD_W'(RISE_STEP);
          rise_cnt_d = rise_cnt_q + RC_W'(1);
        end
      end else if (|bus.blk_down || y_w == Y_FLOOR) begin
        st_d       = GROUND;
        fall_vel_d = FV_W'(1);
      end else begin
        pos_y_d    = COORD_W'(y_fall);
        grav_cnt_d = grav_wrap ? '0 : grav_cnt_q + GC_W'(1);
        fall_vel_d = (grav_wrap && fall_vel_q < FV_W'(FALL_MAX)) ? fall_vel_q + FV_W'(1) : fall_vel_q;
      end
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st_q         <= GROUND;
      pos_x_q      <= COORD_W'(RESET_X);
      pos_y_q      <= COORD_W'(Y_FLOOR);
      dir_q        <= 1'b0;
      shift_q      <= 1'b0;
      jump_prev_q  <= 1'b0;
      anim_frame_q <= '0;
      anim_cnt_q   <= '0;
      rise_cnt_q   <= '0;
      fall_vel_q   <= FV_W'(1);
      grav_cnt_q   <= '0;
    end else begin
      st_q         <= st_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      dir_q        <= dir_d;
      shift_q      <= shift_d;
      jump_prev_q  <= jump_prev_d;
      anim_frame_q <= anim_frame_d;
      anim_cnt_q   <= anim_cnt_d;
      rise_cnt_q   <= rise_cnt_d;
      fall_vel_q   <= fall_vel_d;
      grav_cnt_q   <= grav_cnt_d;
    end
  end
  assign bus.Pos_X      = pos_x_q;
  assign bus.Pos_Y      = pos_y_q;
  assign bus.Shift      = shift_q;
  assign bus.state      = st_q;
  assign bus.direction  = dir_q;
  assign bus.anim_frame = anim_frame_q;
  assign bus.is_sprite  = {1'b0, bus.DrawX} >= x_w && {1'b0, bus.DrawX} < x_w + W1'(SIZE_X) &&
                          {1'b0, bus.DrawY} >= y_w && {1'b0, bus.DrawY} < y_w + W1'(SIZE_Y);
endmodule

// File: tb/tb_sprite_motion.sv
// tb_sprite_motion: directed frame-tick sequence; expected pose values queued per step and popped after the DUT updates
module tb_sprite_motion;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  always #5 Clk = ~Clk;
  sprite_motion_if #(.COORD_W(10), .AF_W(2)) bus();
  sprite_motion dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
  typedef struct {string tag; int sel; logic [31:0] val;} exp_t;
  exp_t q[$];
  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0: obs = 32'(bus.Pos_X);
      1: obs = 32'(bus.Pos_Y);
      2: obs = 32'(bus.state);
      3: obs = 32'(bus.direction);
      4: obs = 32'(bus.anim_frame);
      5: obs = 32'(bus.Shift);
      default: obs = 32'(bus.is_sprite);
    endcase
  endfunction
  task automatic push(input string tag, input int sel, input int val);
    q.push_back('{tag, sel, 32'(val)});
  endtask
  task automatic pose(input string tag, input int x, input int y, input int st);
    push({tag, "_x"}, 0, x);
    push({tag, "_y"}, 1, y);
    push({tag, "_st"}, 2, st);
  endtask
  task automatic check_q();
    exp_t e;
    logic [31:0] o;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
      end
    end
  endtask
  task automatic tick();
    bus.frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    bus.frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
  endtask
  task automatic reset_checks(input string tag);
    pose(tag, 140, 420, 0);
    push({tag, "_dir"}, 3, 0);
    push({tag, "_anim"}, 4, 0);
    push({tag, "_shift"}, 5, 0);
    check_q();
  endtask
  initial begin
    int fall_y[11] = '{405, 406, 407, 408, 409, 410, 412, 414, 416, 418, 420};
    int n;
    bus.frame_clk = 1'b0;
    bus.DrawX = '0; bus.DrawY = '0;
    bus.key_left = 1'b0; bus.key_right = 1'b0; bus.key_jump = 1'b0;
    bus.blk_up = '0; bus.blk_down = '0; bus.blk_left = '0; bus.blk_right = '0;
    repeat (2) @(negedge Clk);
    reset_checks("rst");
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    tick();
    pose("idle", 140, 420, 0);
    push("idle_shift", 5, 0);
    check_q();
    bus.key_right = 1'b1;
    tick();
    push("walk1_x", 0, 142);
    check_q();
    repeat (8) tick();
    push("walk9_anim", 4, 0);
    check_q();
    tick();
    push("walk10_x", 0, 160);
    push("walk10_dir", 3, 0);
    push("walk10_anim", 4, 1);
    check_q();
    bus.key_right = 1'b0;
    bus.DrawX = 10'd160; bus.DrawY = 10'd420; #1 push("hit_tl", 6, 1); check_q();
    bus.DrawX = 10'd179; bus.DrawY = 10'd439; #1 push("hit_br", 6, 1); check_q();
    bus.DrawX = 10'd180; #1 push("hit_xout", 6, 0); check_q();
    bus.DrawX = 10'd159; bus.DrawY = 10'd430; #1 push("hit_xlo", 6, 0); check_q();
    bus.DrawX = 10'd170; bus.DrawY = 10'd440; #1 push("hit_yout", 6, 0); check_q();
    bus.key_jump = 1'b1;
    tick();
    pose("jump1", 160, 418, 1);
    check_q();
    bus.key_jump = 1'b0;
    repeat (7) tick();
    pose("rise8", 160, 404, 1);
    check_q();
    tick();
    pose("rise_end", 160, 404, 2);
    check_q();
    for (int i = 0; i < 11; i++) begin
      tick();
      push($sformatf("fall%0d_y", i), 1, fall_y[i]);
      push($sformatf("fall%0d_st", i), 2, 2);
      check_q();
    end
    tick();
    pose("land", 160, 420, 0);
    check_q();
    bus.key_jump = 1'b1;
    repeat (127) tick();
    pose("hold127", 160, 166, 1);
    check_q();
    tick();
    pose("hold_max", 160, 166, 2);
    check_q();
    n = 0;
    while (bus.state != 2'd0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    assert (n < 200) else begin
      errors++;
      $error("FAIL land_bound observed=%0d expected=<200", n);
    end
    pose("hold_land", 160, 420, 0);
    check_q();
    tick();
    pose("no_retrig", 160, 420, 0);
    check_q();
    bus.key_jump = 1'b0;
    tick();
    bus.key_right = 1'b1;
    repeat (69) tick();
    push("pre_scroll_x", 0, 298);
    push("pre_scroll_shift", 5, 0);
    check_q();
    tick();
    push("scroll_x", 0, 260);
    push("scroll_shift", 5, 1);
    check_q();
    @(negedge Clk);
    push("scroll_pulse_end", 5, 0);
    check_q();
    bus.key_right = 1'b0;
    bus.key_left = 1'b1;
    bus.blk_left = 3'd3;
    tick();
    push("blk_left_x", 0, 260);
    push("blk_left_dir", 3, 1);
    check_q();
    bus.blk_left = 3'd0;
    repeat (70) tick();
    push("left_edge_x", 0, 120);
    check_q();
    tick();
    push("left_bound_x", 0, 120);
    push("left_bound_dir", 3, 1);
    check_q();
    bus.key_left = 1'b0;
    bus.key_jump = 1'b1;
    bus.blk_up = 3'd3;
    tick();
    pose("blk_up_jump", 120, 420, 0);
    check_q();
    bus.key_jump = 1'b0;
    bus.blk_up = 3'd0;
    tick();
    bus.key_jump = 1'b1;
    tick();
    bus.key_jump = 1'b0;
    repeat (8) tick();
    repeat (2) tick();
    pose("mid_fall", 120, 406, 2);
    check_q();
    bus.frame_clk = 1'b0;
    Reset_n = 1'b0;
    #1;
    reset_checks("async_rst");
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    tick();
    pose("post_rst", 140, 420, 0);
    check_q();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_motion.md
# sprite_motion

Parametrised per-frame motion controller for one player sprite. It replaces the fixed-geometry player controller. Once per video frame it advances a GROUND/RISE/FALL state machine with the following features:
- variable-height jumps
- accelerating gravity
- per-state horizontal speed
- tile-collision gating
- screen-scroll requests
- walk-animation sequencing

It sits between the keyboard decode / tile-collision poll logic and the sprite renderer, and it drives the renderer's hit test.

## Interface
Parameters:
- `COORD_W`, 10, coordinate width in bits.
- `X_MIN` / `X_MAX`, 120 / 519, inclusive horizontal play bounds.
- `Y_MIN` / `Y_MAX`, 40 / 439, inclusive vertical play bounds.
- `SIZE_X` / `SIZE_Y`, 20 / 20, sprite width and height in pixels.
- `RESET_X`, 140, X position after reset.
- `WALK_STEP` / `AIR_STEP`, 2 / 1, horizontal pixels per tick on the ground / in the air.
- `RISE_STEP`, 2, upward pixels per tick while in RISE.
- `JUMP_MIN` / `JUMP_MAX`, 8 / 127, minimum and maximum RISE ticks.
- `FALL_MAX`, 4, terminal fall velocity in pixels per tick.
- `GRAV_DIV`, 6, number of ticks per +1 of fall velocity.
- `ANIM_DIV` / `ANIM_FRAMES`, 10 / 3, ticks per animation step and number of walk frames.
- `SCROLL_X`, 299, X threshold above which a scroll is requested.
- `SCROLL_AMT`, 40, pixels subtracted from X on a scroll.

Ports:
- `Clk`, in, 1: system clock.
- `Reset_n`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `frame_clk`, in, 1: vertical-sync frame strobe, asynchronous to `Clk`.
- `DrawX`, `DrawY`, in, `COORD_W` each: current pixel.
- `key_left`, `key_right`, `key_jump`, in, 1 each: decoded held-key levels.
- `blk_up`, `blk_down`, `blk_left`, `blk_right`, in, 3 each: tile type adjacent to the sprite; 0 = empty, nonzero = solid.
- `Pos_X`, `Pos_Y`, out, `COORD_W` each: top-left corner of the sprite.
- `is_sprite`, out, 1: current pixel lies inside the sprite box.
- `Shift`, out, 1: one-cycle scroll request.
- `state`, out, 2: 0 = GROUND, 1 = RISE, 2 = FALL.
- `direction`, out, 1: 0 = facing right, 1 = facing left.
- `anim_frame`, out, `$clog2(ANIM_FRAMES+1)`: 0 = standing, 1..`ANIM_FRAMES` = walk frames.

## Operation
**Tick generation**
- `frame_clk` passes through a 2-flop synchroniser, then an edge detector, producing `tick`: a registered one-`Clk` pulse per rising edge.
- All state updates below occur only on cycles where `tick` = 1.

**State: GROUND**
- If `key_jump` rose since the previous tick and `blk_up` == 0: go to RISE, set `rise_cnt` = 1, and apply `Pos_Y` -= `RISE_STEP`.
  - A held key never re-triggers a jump.
- Else, if `blk_down` == 0 and `Pos_Y` < `Y_MAX`-`SIZE_Y`+1: go to FALL with `fall_vel` = 1. Y is unchanged on this tick.

**State: RISE**
- Go to FALL (Y unchanged on this tick) if any of the following holds:
  - `blk_up` != 0;
  - `Pos_Y` < `Y_MIN` + `RISE_STEP`;
  - `rise_cnt` == `JUMP_MAX`;
  - `key_jump` == 0 and `rise_cnt` >= `JUMP_MIN`.
- Otherwise: `Pos_Y` -= `RISE_STEP` and `rise_cnt` += 1.

**State: FALL**
- If `blk_down` != 0, or `Pos_Y` == `Y_MAX`-`SIZE_Y`+1: go to GROUND and reset `fall_vel` to 1.
- Otherwise: `Pos_Y` = min(`Pos_Y`+`fall_vel`, `Y_MAX`-`SIZE_Y`+1).
  - `grav_cnt` counts ticks; on reaching `GRAV_DIV` it wraps to 0 and `fall_vel` increments, saturating at `FALL_MAX`.

**Horizontal motion**
- Step size is `WALK_STEP` in GROUND, `AIR_STEP` otherwise. The step is evaluated with the pre-tick state.
- Left only (`key_left` and not `key_right`): `direction` = 1. If `blk_left` == 0 and `Pos_X` >= `X_MIN`+step, then `Pos_X` -= step.
- Right only: `direction` = 0. If `blk_right` == 0 and `Pos_X`+`SIZE_X`-1+step <= `X_MAX`, then `Pos_X` += step.
- Both keys or neither: no X motion, `anim_frame` = 0, `anim_cnt` = 0, `direction` held.

**Scroll**
- If the post-move X > `SCROLL_X`: `Pos_X` = post-move X − `SCROLL_AMT`, and `Shift` = 1 for exactly that cycle.

**Animation**
- Applies only in GROUND with exactly one direction key held; a blocked move still animates.
- `anim_cnt` counts ticks up to `ANIM_DIV`-1, then wraps and advances `anim_frame` 0→1→…→`ANIM_FRAMES`→1.
- In RISE or FALL, `anim_frame` holds its value.

**Hit test (combinational)**
- `is_sprite` = (`Pos_X` <= `DrawX` < `Pos_X`+`SIZE_X`) and (`Pos_Y` <= `DrawY` < `Pos_Y`+`SIZE_Y`).

**Arithmetic**
- All comparisons are unsigned at `COORD_W`+1 bits, so no wrap-around can occur.

## Timing
- Reset values:
  - `Pos_X` = `RESET_X`, `Pos_Y` = `Y_MAX`-`SIZE_Y`+1;
  - state = GROUND, `direction` = 0, `anim_frame` = 0, `Shift` = 0;
  - `fall_vel` = 1, all counters 0;
  - synchroniser flops = 0, so no spurious tick is generated after reset.
- Latency: a `frame_clk` rising edge produces `tick` 3 `Clk` cycles later. Outputs update on the edge that samples `tick`.
- `Reset_n` asserted mid-RISE or mid-FALL: all registers return to reset values immediately. The first tick after release behaves as from GROUND.
- Inputs are sampled only on tick cycles; changes between ticks are ignored, except that the `key_jump` edge reference updates every tick.

## Test plan
- Reset, then one tick with no keys: `Pos_X`=140, `Pos_Y`=420, state=0, `Shift`=0.
- `key_right` held for 10 ticks on the ground: `Pos_X`=160, `direction`=0, and `anim_frame`=1 after the 10th tick.
- Tap `key_jump` for 1 tick: RISE lasts 8 ticks (`Pos_Y`=404), then FALL with `fall_vel` 1,1,1,1,1,1,2,… until `Pos_Y`=420 and state=0.
- Hold `key_jump` with `blk_up`=0: RISE ends when `rise_cnt`=127 or on the `Y_MIN` guard.
  - Holding the key after landing does not trigger a second jump.
- `Pos_X`=298, `key_right` held: next tick `Pos_X`=260 and `Shift` is high for one cycle.
- `blk_left`=3 with `key_left` held: `Pos_X` unchanged, `direction`=1.
  - Assert `Reset_n`=0 mid-FALL: all outputs return to reset values within the same cycle.
